// File: rtl/ct_spsram_256x52_ctrl_pkg.sv
// ct_spsram_256x52_ctrl_pkg: shared geometry defaults and controller state encoding.
package ct_spsram_256x52_ctrl_pkg;
   localparam int ADDR_WIDTH_DEF = 8;
   localparam int DATA_WIDTH_DEF = 52;
   typedef enum logic {ST_CLR = 1'b0, ST_RUN = 1'b1} state_e;
endpackage

// File: rtl/ct_spsram_rr_arb2.sv
// ct_spsram_rr_arb2: two-requester round-robin arbiter.
//   clk, rst : clock, async active-high reset (pointer returns to requester 0)
//   en       : arbitration enable; no grant and no pointer movement when low
//   req[1:0] : requests;  gnt[1:0] : one-hot grant, combinational from req
module ct_spsram_rr_arb2
   import ct_spsram_256x52_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   logic ptr_q, ptr_d;
   // ptr_q names the requester that wins a tie
   assign gnt[0] = en & req[0] & (~req[1] | ~ptr_q);
   assign gnt[1] = en & req[1] & (~req[0] | ptr_q);
   assign ptr_d  = gnt[0] ? 1'b1 : gnt[1] ? 1'b0 : ptr_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) ptr_q <= 1'b0;
      else     ptr_q <= ptr_d;
endmodule

// File: rtl/ct_spsram_256x52_ctrl.sv
// ct_spsram_256x52_ctrl: single-port SRAM controller with clear sweep and two arbitrated requesters.
//   forever_cpuclk, cpurst       : clock, async active-high reset
//   clr_req / clr_busy           : restart clear sweep / sweep in progress
//   pN_req/wr/addr/wdata/wmask   : requester N access (N=0,1)
//   pN_gnt, pN_rvld, pN_rdata    : grant, read valid, read data
//   sram_a/cen/gwen/wen/d, sram_q: SRAM macro interface (enables active-low)
module ct_spsram_256x52_ctrl
   import ct_spsram_256x52_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst,
   input  logic                  clr_req,
   output logic                  clr_busy,
   input  logic                  p0_req,
   input  logic                  p0_wr,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   input  logic [DATA_WIDTH-1:0] p0_wmask,
   output logic                  p0_gnt,
   output logic                  p0_rvld,
   output logic [DATA_WIDTH-1:0] p0_rdata,
   input  logic                  p1_req,
   input  logic                  p1_wr,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   input  logic [DATA_WIDTH-1:0] p1_wmask,
   output logic                  p1_gnt,
   output logic                  p1_rvld,
   output logic [DATA_WIDTH-1:0] p1_rdata,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);
   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic                    p0_rvld_q, p1_rvld_q;
   logic [1:0]              gnt;
   logic                    run, acc, wr_acc, sel_wr;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_wdata, sel_wmask;

   assign run = (state_q == ST_RUN);

   ct_spsram_rr_arb2 u_arb (
      .clk (forever_cpuclk),
      .rst (cpurst),
      .en  (run),
      .req ({p1_req, p0_req}),
      .gnt (gnt)
   );

   assign p0_gnt    = gnt[0];
   assign p1_gnt    = gnt[1];
   assign sel_wr    = gnt[1] ? p1_wr    : p0_wr;
   assign sel_addr  = gnt[1] ? p1_addr  : p0_addr;
   assign sel_wdata = gnt[1] ? p1_wdata : p0_wdata;
   assign sel_wmask = gnt[1] ? p1_wmask : p0_wmask;
   assign acc       = |gnt;
   assign wr_acc    = acc & sel_wr;

   // clr_req is only honoured in RUN; the counter parks at 0 so a new sweep starts there
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      if (!run) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == '1) state_d = ST_RUN;
      end else if (clr_req) begin
         state_d = ST_CLR;
      end
   end

   always_ff @(posedge forever_cpuclk or posedge cpurst)
      if (cpurst) begin
         state_q   <= ST_CLR;
         cnt_q     <= '0;
         p0_rvld_q <= 1'b0;
         p1_rvld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         p0_rvld_q <= gnt[0] & ~p0_wr;
         p1_rvld_q <= gnt[1] & ~p1_wr;
      end

   // the clear sweep is a full-width write of zero; gnt is forced low in CLR
   assign clr_busy  = !run;
   assign sram_cen  = run & ~acc;
   assign sram_gwen = run & ~wr_acc;
   assign sram_wen  = !run ? '0 : wr_acc ? ~sel_wmask : '1;
   assign sram_d    = wr_acc ? sel_wdata : '0;
   assign sram_a    = !run ? cnt_q : acc ? sel_addr : '0;
   assign p0_rvld   = p0_rvld_q;
   assign p1_rvld   = p1_rvld_q;
   assign p0_rdata  = sram_q;
   assign p1_rdata  = sram_q;
endmodule

// File: tb/tb_ct_spsram_256x52_ctrl.sv
// tb_ct_spsram_256x52_ctrl: directed bench with behavioural SRAM for ct_spsram_256x52_ctrl.
module tb_ct_spsram_256x52_ctrl;
   localparam int AW = 8;
   localparam int DW = 52;
   localparam logic [DW-1:0] ALL1 = '1;
   localparam logic [DW-1:0] V    = 52'hA_BCDE_F012_3456;
   localparam logic [DW-1:0] M    = 52'h0_0000_03FF_FFFF;
   localparam logic [DW-1:0] NM   = ~M;

   logic          forever_cpuclk, cpurst, clr_req, clr_busy;
   logic          p0_req, p0_wr, p0_gnt, p0_rvld;
   logic [AW-1:0] p0_addr;
   logic [DW-1:0] p0_wdata, p0_wmask, p0_rdata;
   logic          p1_req, p1_wr, p1_gnt, p1_rvld;
   logic [AW-1:0] p1_addr;
   logic [DW-1:0] p1_wdata, p1_wmask, p1_rdata;
   logic [AW-1:0] sram_a;
   logic          sram_cen, sram_gwen;
   logic [DW-1:0] sram_wen, sram_d, sram_q;
   logic [DW-1:0] mem [256];
   int            checks, failures;

   ct_spsram_256x52_ctrl dut (
      .forever_cpuclk(forever_cpuclk), .cpurst(cpurst), .clr_req(clr_req), .clr_busy(clr_busy),
      .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
      .p0_gnt(p0_gnt), .p0_rvld(p0_rvld), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
      .p1_gnt(p1_gnt), .p1_rvld(p1_rvld), .p1_rdata(p1_rdata),
      .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
      .sram_d(sram_d), .sram_q(sram_q)
   );

   initial forever_cpuclk = 1'b0;
   always #5 forever_cpuclk = ~forever_cpuclk;

   always @(posedge forever_cpuclk)
      if (!sram_cen) begin
         if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
         else            sram_q      <= mem[sram_a];
      end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sweep(input int n, input int clr_at);
      for (int i = 0; i < n; i++) begin
         clr_req = (i == clr_at);
         #1;
         chk("swp_a", {56'd0, sram_a}, 64'(i));
         chk("swp_ctl", {clr_busy, sram_cen, sram_gwen, p0_gnt, p1_gnt}, 5'b10000);
         chk("swp_wen", sram_wen, '0);
         chk("swp_d", sram_d, '0);
         @(negedge forever_cpuclk);
      end
      clr_req = 1'b0;
   endtask

   initial begin
      checks = 0; failures = 0;
      sram_q = '0;
      for (int i = 0; i < 256; i++) mem[i] = 52'hC_5A5A_0000_0000 | 52'(i);
      cpurst = 1'b1; clr_req = 1'b0;
      p0_req = 0; p0_wr = 0; p0_addr = '0; p0_wdata = '0; p0_wmask = '0;
      p1_req = 0; p1_wr = 0; p1_addr = '0; p1_wdata = '0; p1_wmask = '0;
      repeat (3) @(negedge forever_cpuclk);
      #1;
      chk("rst_flags", {clr_busy, p0_gnt, p1_gnt, p0_rvld, p1_rvld}, 5'b10000);
      chk("rst_a", sram_a, 0);
      chk("rst_cen", sram_cen, 0);
      @(negedge forever_cpuclk);
      cpurst = 1'b0;
      sweep(50, -1);
      #1;
      chk("pre_rst_a", sram_a, 8'd50);
      cpurst = 1'b1;
      #1;
      chk("mid_rst", {clr_busy, sram_a}, {1'b1, 8'd0});
      repeat (2) @(negedge forever_cpuclk);
      cpurst = 1'b0;
      sweep(256, 100);
      #1;
      chk("idle_ctl", {clr_busy, sram_cen, sram_gwen, p0_gnt, p1_gnt}, 5'b01100);
      chk("idle_a", sram_a, 0);
      chk("idle_wen", sram_wen, ALL1);
      chk("idle_d", sram_d, 0);

      @(negedge forever_cpuclk);
      p0_req = 1; p0_wr = 0; p0_addr = 8'h80;
      #1;
      chk("rd80_gnt", {p0_gnt, p1_gnt, sram_cen, sram_gwen}, 4'b1001);
      chk("rd80_a", sram_a, 8'h80);
      chk("rd80_wen", sram_wen, ALL1);
      @(negedge forever_cpuclk);
      p0_req = 0;
      #1;
      chk("rd80_rvld", {p0_rvld, p1_rvld}, 2'b10);
      chk("rd80_data", p0_rdata, 0);

      @(negedge forever_cpuclk);
      p0_req = 1; p0_wr = 1; p0_addr = 8'h10; p0_wdata = V; p0_wmask = ALL1;
      #1;
      chk("wr10_ctl", {p0_gnt, p1_gnt, sram_cen, sram_gwen}, 4'b1000);
      chk("wr10_wen", sram_wen, 0);
      chk("wr10_d", sram_d, V);
      chk("wr10_a", sram_a, 8'h10);
      @(negedge forever_cpuclk);
      p0_req = 0; p0_wr = 0; p1_req = 1; p1_wr = 0; p1_addr = 8'h10;
      #1;
      chk("rd10_gnt", {p0_gnt, p1_gnt, p0_rvld}, 3'b010);
      @(negedge forever_cpuclk);
      p1_req = 0;
      #1;
      chk("rd10_rvld", {p0_rvld, p1_rvld}, 2'b01);
      chk("rd10_data", p1_rdata, V);

      @(negedge forever_cpuclk);
      p0_req = 1; p0_wr = 0; p0_addr = 8'h10;
      p1_req = 1; p1_wr = 0; p1_addr = 8'h80;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("rr_gnt", {p0_gnt, p1_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
         chk("rr_rvld", {p0_rvld, p1_rvld}, (k == 0) ? 2'b00 : (k % 2 == 1) ? 2'b10 : 2'b01);
         if (k > 0) chk("rr_data", (k % 2 == 1) ? p0_rdata : p1_rdata, (k % 2 == 1) ? V : '0);
         @(negedge forever_cpuclk);
      end
      p0_req = 0; p1_req = 0;
      #1;
      chk("rr_last", {p0_rvld, p1_rvld}, 2'b01);
      chk("rr_last_data", p1_rdata, 0);

      @(negedge forever_cpuclk);
      p1_req = 1; p1_wr = 1; p1_addr = 8'h20; p1_wdata = ALL1; p1_wmask = M;
      #1;
      chk("wm_gnt", {p0_gnt, p1_gnt, sram_gwen}, 3'b010);
      chk("wm_wen", sram_wen, NM);
      chk("wm_d", sram_d, ALL1);
      @(negedge forever_cpuclk);
      p1_wr = 0;
      #1;
      chk("raw_gnt", {p1_gnt, sram_gwen, sram_a}, {2'b11, 8'h20});
      @(negedge forever_cpuclk);
      p1_req = 0;
      #1;
      chk("raw_rvld", {p0_rvld, p1_rvld}, 2'b01);
      chk("raw_data", p1_rdata, M);

      @(negedge forever_cpuclk);
      p0_req = 1; p0_wr = 1; p0_addr = 8'h20; p0_wdata = '0; p0_wmask = '0;
      #1;
      chk("zm_ctl", {p0_gnt, sram_cen, sram_gwen}, 3'b100);
      chk("zm_wen", sram_wen, ALL1);
      @(negedge forever_cpuclk);
      p0_wr = 0;
      #1;
      chk("zm_rgnt", {p0_gnt, sram_gwen}, 2'b11);
      @(negedge forever_cpuclk);
      p0_req = 0;
      #1;
      chk("zm_rvld", {p0_rvld, p1_rvld}, 2'b10);
      chk("zm_data", p0_rdata, M);

      @(negedge forever_cpuclk);
      p0_req = 1; p0_wr = 0; p0_addr = 8'h10; clr_req = 1;
      #1;
      chk("cr_gnt", {p0_gnt, clr_busy}, 2'b10);
      @(negedge forever_cpuclk);
      p0_req = 0; clr_req = 0; p1_req = 1; p1_wr = 0; p1_addr = 8'h10;
      #1;
      chk("cr_rvld", {p0_rvld, clr_busy, p1_gnt}, 3'b110);
      chk("cr_data", p0_rdata, V);
      sweep(256, -1);
      #1;
      chk("post_gnt", {clr_busy, p1_gnt}, 2'b01);
      @(negedge forever_cpuclk);
      p1_req = 0;
      #1;
      chk("post_rvld", {p0_rvld, p1_rvld}, 2'b01);
      chk("post_data", p1_rdata, 0);

      @(negedge forever_cpuclk);
      p0_req = 1; p0_wr = 0; p0_addr = 8'h80;
      #1;
      chk("mr_gnt", p0_gnt, 1);
      cpurst = 1'b1;
      #1;
      chk("mr_flags", {clr_busy, p0_gnt, p0_rvld, p1_rvld}, 4'b1000);
      chk("mr_a", sram_a, 0);
      repeat (2) @(negedge forever_cpuclk);
      cpurst = 1'b0; p0_req = 0;
      #1;
      chk("mr_rel", {clr_busy, sram_a}, {1'b1, 8'd0});
      @(negedge forever_cpuclk);
      #1;
      chk("mr_next_a", sram_a, 8'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
